// File: rtl/pipe_pkg.sv
// Shared definitions for pipeline stage boundaries: stage buffer states,
// occupancy width and per-boundary payload widths.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HALF  = 2'd1,
    ST_FULL  = 2'd2
  } stage_state_t;

  localparam int unsigned OCC_W = 2;

  localparam int unsigned IF_ID_W  = 64;
  localparam int unsigned ID_EX_W  = 160;
  localparam int unsigned EX_MEM_W = 112;
  localparam int unsigned MEM_WB_W = 72;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-high reset, used for perf counters.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset)
      count <= '0;
    else if (inc && (count != '1))
      count <= count + 1'b1;
  end

endmodule

// File: rtl/pipe_stage_buf.sv
// Valid/ready pipeline stage register with optional two-entry skid buffer,
// synchronous flush and a saturating backpressure cycle counter.
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int unsigned       WIDTH     = 32,
  parameter int unsigned       SKID      = 1,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0,
  parameter int unsigned       CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [OCC_W-1:0] occupancy,
  output logic [CNT_W-1:0] bp_cycles
);

  stage_state_t     state, state_n;
  logic [WIDTH-1:0] main_q, main_n;
  logic [WIDTH-1:0] skid_q, skid_n;
  logic             xfer_in, xfer_out;

  assign xfer_in   = in_valid && in_ready;
  assign xfer_out  = out_valid && out_ready;
  assign out_valid = (state != ST_EMPTY);
  assign out_data  = main_q;

  always_comb begin
    state_n = state;
    main_n  = main_q;
    skid_n  = skid_q;
    unique case (state)
      ST_EMPTY: begin
        if (xfer_in) begin
          state_n = ST_HALF;
          main_n  = in_data;
        end
      end
      ST_HALF: begin
        if (xfer_in && xfer_out) begin
          main_n = in_data;
        end else if (xfer_in) begin
          state_n = ST_FULL;
          skid_n  = in_data;
        end else if (xfer_out) begin
          state_n = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (xfer_out) begin
          state_n = ST_HALF;
          main_n  = skid_q;
        end
      end
      default: state_n = ST_EMPTY;
    endcase
  end

  // Flush discards all held entries; an out-transfer this cycle has already
  // been sampled downstream, so nothing more is needed for it.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      state  <= ST_EMPTY;
      main_q <= RESET_VAL;
      skid_q <= RESET_VAL;
    end else begin
      state  <= state_n;
      main_q <= main_n;
      skid_q <= skid_n;
    end
  end

  always_comb begin
    occupancy = '0;
    unique case (state)
      ST_EMPTY: occupancy = 2'd0;
      ST_HALF:  occupancy = 2'd1;
      ST_FULL:  occupancy = 2'd2;
      default:  occupancy = 2'd0;
    endcase
  end

  // With the skid entry, ready is a flop of "next state is not FULL", which
  // removes any combinational path from out_ready to in_ready.
  if (SKID != 0) begin : g_skid
    logic rdy_q;
    always_ff @(posedge clk) begin
      if (reset || flush)
        rdy_q <= 1'b1;
      else
        rdy_q <= (state_n != ST_FULL);
    end
    assign in_ready = rdy_q;
  end else begin : g_noskid
    assign in_ready = !out_valid || out_ready;
  end

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_bp_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (out_valid && !out_ready),
    .count(bp_cycles)
  );

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed self-checking bench for pipe_stage_buf: skid build, single-entry
// build and a narrow-counter build sharing one clock and reset.
module tb_pipe_stage_buf;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int unsigned errors = 0;
  int unsigned checks = 0;

  // DUT A: SKID=1, WIDTH=8, distinctive reset value
  logic       a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [7:0] a_in_data, a_out_data;
  logic [1:0] a_occ;
  logic [15:0] a_bp;

  // DUT B: SKID=0
  logic       b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [7:0] b_in_data, b_out_data;
  logic [1:0] b_occ;
  logic [15:0] b_bp;

  // DUT C: SKID=1, CNT_W=3
  logic       c_flush, c_in_valid, c_in_ready, c_out_valid, c_out_ready;
  logic [7:0] c_in_data, c_out_data;
  logic [1:0] c_occ;
  logic [2:0] c_bp;

  pipe_stage_buf #(.WIDTH(8), .SKID(1), .RESET_VAL(8'hE5), .CNT_W(16)) dut_a (
    .clk(clk), .reset(reset), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .occupancy(a_occ), .bp_cycles(a_bp)
  );

  pipe_stage_buf #(.WIDTH(8), .SKID(0), .RESET_VAL(8'h00), .CNT_W(16)) dut_b (
    .clk(clk), .reset(reset), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .occupancy(b_occ), .bp_cycles(b_bp)
  );

  pipe_stage_buf #(.WIDTH(8), .SKID(1), .RESET_VAL(8'h00), .CNT_W(3)) dut_c (
    .clk(clk), .reset(reset), .flush(c_flush),
    .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
    .occupancy(c_occ), .bp_cycles(c_bp)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    a_flush = 0; a_in_valid = 1; a_in_data = 8'h77; a_out_ready = 0;
    b_flush = 0; b_in_valid = 1; b_in_data = 8'h77; b_out_ready = 0;
    c_flush = 0; c_in_valid = 1; c_in_data = 8'h77; c_out_ready = 0;
    cyc(); cyc();

    chk("a_rst_out_valid", a_out_valid, 0);
    chk("a_rst_in_ready",  a_in_ready,  1);
    chk("a_rst_out_data",  a_out_data,  8'hE5);
    chk("a_rst_occ",       a_occ,       0);
    chk("a_rst_bp",        a_bp,        0);
    chk("b_rst_out_valid", b_out_valid, 0);
    chk("c_rst_bp",        c_bp,        0);

    reset = 0;
    a_in_valid = 0; b_in_valid = 0; c_in_valid = 0;

    // Streaming 1..8 on A with downstream always ready
    a_out_ready = 1;
    for (int i = 1; i <= 8; i++) begin
      a_in_valid = 1; a_in_data = 8'(i);
      #1;
      chk($sformatf("a_stream_in_ready_%0d", i), a_in_ready, 1);
      cyc();
      chk($sformatf("a_stream_valid_%0d", i), a_out_valid, 1);
      chk($sformatf("a_stream_data_%0d", i),  a_out_data, i);
      chk($sformatf("a_stream_occ_%0d", i),   a_occ, 1);
    end
    a_in_valid = 0;
    cyc();
    chk("a_stream_drain_valid", a_out_valid, 0);
    chk("a_stream_drain_occ",   a_occ, 0);
    chk("a_stream_bp",          a_bp, 0);

    // Backpressure: A accepted, B goes to skid, C refused
    a_out_ready = 0;
    a_in_valid = 1; a_in_data = 8'h0A; #1;
    chk("a_bp_rdy_A", a_in_ready, 1);
    cyc();
    a_in_data = 8'h0B; #1;
    chk("a_bp_rdy_B", a_in_ready, 1);
    cyc();
    a_in_data = 8'h0C; #1;
    chk("a_bp_rdy_C0", a_in_ready, 0);
    chk("a_bp_occ2",   a_occ, 2);
    chk("a_bp_head_A", a_out_data, 8'h0A);
    cyc();
    chk("a_bp_rdy_C1", a_in_ready, 0);
    chk("a_bp_hold_A", a_out_data, 8'h0A);
    cyc();
    a_out_ready = 1; #1;
    chk("a_bp_rel_rdy", a_in_ready, 0);
    chk("a_bp_out_A",   a_out_data, 8'h0A);
    cyc();
    chk("a_bp_out_B",     a_out_data, 8'h0B);
    chk("a_bp_rdy_back",  a_in_ready, 1);
    chk("a_bp_occ_after", a_occ, 1);
    cyc();
    chk("a_bp_out_C",   a_out_data, 8'h0C);
    chk("a_bp_valid_C", a_out_valid, 1);
    a_in_valid = 0;
    cyc();
    chk("a_bp_empty", a_out_valid, 0);
    chk("a_bp_count", a_bp, 3);

    // Flush while FULL; head 0x11 still leaves in the flush cycle
    a_out_ready = 0;
    a_in_valid = 1; a_in_data = 8'h11; cyc();
    a_in_data = 8'h22; cyc();
    chk("a_fl_full_occ", a_occ, 2);
    chk("a_fl_bp_pre",   a_bp, 4);
    a_flush = 1; a_in_data = 8'h0D; a_out_ready = 1; #1;
    chk("a_fl_head", a_out_data, 8'h11);
    cyc();
    a_flush = 0; a_in_valid = 0;
    chk("a_fl_valid",   a_out_valid, 0);
    chk("a_fl_occ",     a_occ, 0);
    chk("a_fl_data",    a_out_data, 8'hE5);
    chk("a_fl_in_rdy",  a_in_ready, 1);
    chk("a_fl_bp_keep", a_bp, 4);
    cyc();
    chk("a_fl_no_D", a_out_valid, 0);

    // Flush while HALF with in_ready=1: 0x44 must be discarded
    a_out_ready = 0;
    a_in_valid = 1; a_in_data = 8'h33; cyc();
    a_flush = 1; a_in_data = 8'h44; #1;
    chk("a_flh_rdy", a_in_ready, 1);
    cyc();
    a_flush = 0; a_in_valid = 0;
    chk("a_flh_valid", a_out_valid, 0);
    chk("a_flh_bp",    a_bp, 5);
    cyc();
    chk("a_flh_no_44", a_out_valid, 0);

    // SKID=0: combinational ready follows out_ready
    b_out_ready = 0;
    b_in_valid = 1; b_in_data = 8'h21; #1;
    chk("b_rdy_empty", b_in_ready, 1);
    cyc();
    b_in_data = 8'h22; #1;
    chk("b_rdy_stall", b_in_ready, 0);
    chk("b_occ1",      b_occ, 1);
    chk("b_head",      b_out_data, 8'h21);
    cyc();
    chk("b_hold", b_out_data, 8'h21);
    b_out_ready = 1; #1;
    chk("b_rdy_same_cycle", b_in_ready, 1);
    cyc();
    chk("b_pass_data",  b_out_data, 8'h22);
    chk("b_pass_valid", b_out_valid, 1);
    b_in_valid = 0;
    cyc();
    chk("b_drain", b_out_valid, 0);
    chk("b_bp",    b_bp, 1);

    // Counter saturation at CNT_W=3
    c_in_valid = 1; c_in_data = 8'h01; c_out_ready = 0;
    cyc();
    c_in_valid = 0;
    for (int i = 0; i < 6; i++) cyc();
    chk("c_bp_6", c_bp, 6);
    for (int i = 0; i < 6; i++) cyc();
    chk("c_bp_sat", c_bp, 7);
    for (int i = 0; i < 3; i++) cyc();
    chk("c_bp_stay", c_bp, 7);
    chk("c_head",    c_out_data, 8'h01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_stage_buf.md
# pipe_stage_buf

Parametrised pipeline stage register for the next-generation core: a registered valid/ready stage with optional two-entry skid buffer, synchronous flush and a saturating backpressure counter. It replaces the fixed-width per-field flop banks between pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB). Each stage boundary packs its fields into one `WIDTH`-bit payload and instantiates this block. Stage stalls are expressed through the handshake instead of a global stall vector.

## Interface
- `WIDTH`, 32: payload width in bits, ≥1.
- `SKID`, 1: 1 = two-entry skid, `in_ready` registered; 0 = single entry, `in_ready` combinational.
- `RESET_VAL`, 0: payload value loaded on reset/flush, `WIDTH` bits.
- `CNT_W`, 16: width of the backpressure counter, ≥1.

Ports:
- `clk`  in  1  the single clock; all state on rising edge.
- `reset`  in  1  synchronous, active-high.
- `flush`  in  1  synchronous kill of all held entries (exception/branch redirect).
- `in_valid`  in  1  upstream has payload.
- `in_ready`  out  1  stage can accept this cycle.
- `in_data`  in  WIDTH  upstream payload.
- `out_valid`  out  1  stage holds valid payload.
- `out_ready`  in  1  downstream accepts this cycle.
- `out_data`  out  WIDTH  payload of main entry.
- `occupancy`  out  2  entries held (0..2; ≤1 when SKID=0).
- `bp_cycles`  out  CNT_W  saturating count of cycles with `out_valid && !out_ready`.

## Operation
- Transfer in: `in_valid && in_ready`. Transfer out: `out_valid && out_ready`.
- States (SKID=1): EMPTY, HALF (main valid), FULL (main + skid valid).
  - EMPTY: accept → HALF, main←in_data.
  - HALF: accept & out → HALF, main←in_data. Accept & no out → FULL, skid←in_data. Out & no accept → EMPTY. Neither → hold.
  - FULL: `in_ready`=0. Out → HALF, main←skid. Otherwise hold.
- SKID=0: only EMPTY/HALF; `in_ready = !out_valid || out_ready`.
- SKID=1: `in_ready` = (state != FULL), driven straight from a flop; no ready path from `out_ready` to `in_ready`.
- `out_valid` = (state != EMPTY); `out_data` = main register; `occupancy` = 0/1/2 per state.
- `flush`: next state EMPTY; main and skid ← `RESET_VAL`. Payload presented in the flush cycle is discarded even if `in_ready`=1. An out-transfer in the flush cycle still completes, because downstream samples it.
- `reset`: same as flush, plus `bp_cycles` ← 0.
- `bp_cycles`: increments when `out_valid && !out_ready`, saturates at 2^CNT_W−1. It is not cleared by flush.
- Payload ordering is strictly FIFO; no entry is ever dropped or duplicated outside flush.

## Timing
- Latency: accepted payload appears on `out_data` with `out_valid`=1 the next cycle.
- Throughput: 1 transfer/cycle sustained when `out_ready`=1.
- After `out_ready` deasserts in HALF, SKID=1 absorbs one more beat. `in_ready` falls the cycle after entering FULL.
- After leaving FULL, `in_ready` rises the following cycle.
- Reset values: `in_ready`=1, `out_valid`=0, `out_data`=`RESET_VAL`, `occupancy`=0, `bp_cycles`=0.
- `flush` and `reset` asserted together behave as reset. Asserting either mid-FULL empties the stage in one cycle.

## Structure
- Shared package `pipe_pkg`: state enum (EMPTY/HALF/FULL), the occupancy width constant, and per-stage payload width constants (`ID_EX_W`, etc.).
- One sub-module, `sat_counter` (parameter `CNT_W`; ports `clk`, `reset`, `inc`, `count`), reused by the perf counters.
- Payload packing/unpacking stays in the instantiating stage, not in this block.

## Test plan
- Reset: hold `reset` 2 cycles with `in_valid`=1 → `out_valid`=0, `in_ready`=1, `out_data`=`RESET_VAL`, `occupancy`=0.
- Streaming (SKID=1): `out_ready`=1, send 0x1..0x8 back-to-back → outputs 0x1..0x8 on consecutive cycles, each 1 cycle after accept; `in_ready` never drops.
- Backpressure: send 0xA, 0xB, 0xC with `out_ready`=0 → 0xA, 0xB accepted, `in_ready`=0 from the 3rd cycle, `occupancy`=2. Release → outputs 0xA, 0xB, 0xC in order; `bp_cycles` equals the stalled cycles.
- Flush while FULL: `flush`=1 with 0xD on input → next cycle `out_valid`=0, `occupancy`=0, 0xD never appears; `bp_cycles` unchanged.
- SKID=0: hold `out_ready`=0 with `out_valid`=1 → `in_ready`=0 in the same cycle. Raise `out_ready` → `in_ready`=1 in the same cycle, with simultaneous in/out transfer.
- Counter saturation: CNT_W=3, hold backpressure 12 cycles → `bp_cycles`=7 and stays 7.
